// File: rtl/requant_stage.sv
// Requantization stage: optional ReLU, fixed-point multiply, round-half-up shift and zero-point.
// Three registered stages under a single global stall; neuron index tracked on output transfers.
module requant_stage #(
    parameter int unsigned ACC_W = 32,
    parameter int unsigned OUT_W = 8,
    parameter int unsigned IDX_W = 10
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cfg_valid,
    output logic             o_cfg_ready,
    input  logic [ACC_W-1:0] i_cfg_mult,
    input  logic [ACC_W-1:0] i_cfg_shift,
    input  logic [7:0]       i_cfg_out_zp,
    input  logic             i_cfg_linear,
    input  logic [IDX_W-1:0] i_cfg_len,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [ACC_W-1:0] i_acc,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [OUT_W-1:0] o_act,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_last
);

    localparam int unsigned ProdW = 2 * ACC_W;

    logic [ACC_W-1:0]        mult_q, shift_q;
    logic [7:0]              zp_q;
    logic                    linear_q;
    logic [IDX_W-1:0]        len_q, cnt_q, cnt_d;

    logic                    v1_q, v2_q, v3_q;
    logic signed [ACC_W-1:0] r1_q, r1_d;
    logic signed [ProdW-1:0] p2_q, p2_d;
    logic [OUT_W-1:0]        act_q, act_d;

    logic                    advance, cfg_load, out_xfer, at_last;
    logic [ACC_W-1:0]        ts;
    logic signed [ProdW-1:0] rnd_sum;

    always_comb begin
        advance     = !v3_q || i_ready;
        o_ready     = advance;
        o_cfg_ready = !(v1_q || v2_q || v3_q || i_valid);
        cfg_load    = i_cfg_valid && o_cfg_ready;
        out_xfer    = v3_q && i_ready;
        at_last     = (cnt_q == len_q - IDX_W'(1));

        r1_d = (!linear_q && i_acc[ACC_W-1]) ? '0 : i_acc;
        p2_d = $signed({{ACC_W{r1_q[ACC_W-1]}}, r1_q}) * $signed({{ACC_W{mult_q[ACC_W-1]}}, mult_q});

        // Only the low OUT_W bits of (s + zp) survive, so the sum is formed at full width
        ts      = ACC_W'(31) - shift_q;
        rnd_sum = p2_q + (ProdW'(1) << (ts - ACC_W'(1)));
        act_d   = OUT_W'((rnd_sum >>> ts) + ProdW'($signed(zp_q)));

        cnt_d = cnt_q;
        if (cfg_load) begin
            cnt_d = '0;
        end else if (out_xfer) begin
            cnt_d = at_last ? '0 : cnt_q + IDX_W'(1);
        end

        o_valid = v3_q;
        o_act   = act_q;
        o_idx   = cnt_q;
        o_last  = v3_q && at_last;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mult_q   <= '0;
            shift_q  <= '0;
            zp_q     <= '0;
            linear_q <= 1'b0;
            len_q    <= '0;
            cnt_q    <= '0;
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            v3_q     <= 1'b0;
            r1_q     <= '0;
            p2_q     <= '0;
            act_q    <= '0;
        end else begin
            if (cfg_load) begin
                mult_q   <= i_cfg_mult;
                shift_q  <= i_cfg_shift;
                zp_q     <= i_cfg_out_zp;
                linear_q <= i_cfg_linear;
                len_q    <= i_cfg_len;
            end
            cnt_q <= cnt_d;
            if (advance) begin
                v1_q  <= i_valid;
                v2_q  <= v1_q;
                v3_q  <= v2_q;
                r1_q  <= r1_d;
                p2_q  <= p2_d;
                act_q <= act_d;
            end
        end
    end

endmodule

// File: tb/tb_requant_stage.sv
// Bench for requant_stage: directed cases plus randomized streams against an arithmetic model.
module tb_requant_stage;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_cfg_valid;
    logic        o_cfg_ready;
    logic [31:0] i_cfg_mult;
    logic [31:0] i_cfg_shift;
    logic [7:0]  i_cfg_out_zp;
    logic        i_cfg_linear;
    logic [9:0]  i_cfg_len;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_acc;
    logic        o_valid;
    logic        i_ready;
    logic [7:0]  o_act;
    logic [9:0]  o_idx;
    logic        o_last;

    requant_stage #(.ACC_W(32), .OUT_W(8), .IDX_W(10)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_cfg_valid (i_cfg_valid),
        .o_cfg_ready (o_cfg_ready),
        .i_cfg_mult  (i_cfg_mult),
        .i_cfg_shift (i_cfg_shift),
        .i_cfg_out_zp(i_cfg_out_zp),
        .i_cfg_linear(i_cfg_linear),
        .i_cfg_len   (i_cfg_len),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_acc       (i_acc),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_act       (o_act),
        .o_idx       (o_idx),
        .o_last      (o_last)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h required 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model state
    typedef struct {
        logic [7:0] act;
        int         acc_cyc;
        bit         chk_lat;
    } exp_t;

    exp_t q[$];
    int   m_mult = 0, m_shift = 0, m_zp = 0, m_len = 0, m_idx = 0;
    bit   m_lin = 1'b0;
    bit   head_seen = 1'b0;
    int   last_acc = 0;

    function automatic logic [7:0] ref_act(input int acc);
        longint r, p, s;
        int     ts;
        r = acc;
        if (!m_lin && acc < 0) r = 0;
        p  = r * longint'(m_mult);
        ts = 31 - m_shift;
        s  = (p + (longint'(1) <<< (ts - 1))) >>> ts;
        return 8'(s + longint'(m_zp));
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send(input int acc, input bit chk_lat);
        int n;
        n       = 0;
        i_valid = 1'b1;
        i_acc   = acc;
        @(negedge i_clk);
        while (!o_ready && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        if (n >= 200) begin
            check_eq("send_timeout", 64'(n), 64'd0);
        end else begin
            q.push_back('{ref_act(acc), cyc, chk_lat});
            last_acc = cyc;
        end
        tick();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || o_valid) && n < 300) begin
            @(negedge i_clk);
            n++;
        end
        if (n >= 300) check_eq("drain_timeout", 64'(q.size()), 64'd0);
        tick();
    endtask

    task automatic do_cfg(input int mult, input int shift, input int zp, input bit lin,
                          input int len, input bit busy);
        int n;
        n            = 0;
        i_cfg_mult   = mult;
        i_cfg_shift  = shift;
        i_cfg_out_zp = zp[7:0];
        i_cfg_linear = lin;
        i_cfg_len    = len[9:0];
        i_cfg_valid  = 1'b1;
        @(negedge i_clk);
        if (busy) check_eq("cfg_busy", 64'(o_cfg_ready), 64'd0);
        while (!o_cfg_ready && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        if (n >= 200) check_eq("cfg_timeout", 64'(o_cfg_ready), 64'd1);
        if (busy) check_eq("cfg_accept_cyc", 64'(cyc), 64'(last_acc + 4));
        tick();
        i_cfg_valid = 1'b0;
        m_mult  = mult;
        m_shift = shift;
        m_zp    = zp;
        m_lin   = lin;
        m_len   = len;
        m_idx   = 0;
    endtask

    // Output monitor: every valid cycle is compared against the head of the model queue
    initial begin
        exp_t mon_e;
        bit   exp_last;
        forever begin
            @(negedge i_clk);
            if (!i_rst && o_valid) begin
                if (q.size() == 0) begin
                    check_eq("unexpected_valid", 64'(o_valid), 64'd0);
                end else begin
                    mon_e = q[0];
                    if (!head_seen && mon_e.chk_lat)
                        check_eq("latency", 64'(cyc - mon_e.acc_cyc), 64'd3);
                    head_seen = 1'b1;
                    exp_last  = (m_idx == ((m_len + 1023) % 1024));
                    check_eq("act", 64'(o_act), 64'(mon_e.act));
                    check_eq("idx", 64'(o_idx), 64'(m_idx));
                    check_eq("last", 64'(o_last), 64'(exp_last));
                    if (!i_ready) begin
                        check_eq("ready_stall", 64'(o_ready), 64'd0);
                    end else begin
                        void'(q.pop_front());
                        m_idx     = exp_last ? 0 : (m_idx + 1) % 1024;
                        head_seen = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit rdone;
        int guard;
        i_rst = 1'b1; i_cfg_valid = 1'b0; i_cfg_mult = '0; i_cfg_shift = '0;
        i_cfg_out_zp = '0; i_cfg_linear = 1'b0; i_cfg_len = '0;
        i_valid = 1'b0; i_acc = '0; i_ready = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        check_eq("rst_valid", 64'(o_valid), 64'd0);
        check_eq("rst_act", 64'(o_act), 64'd0);
        check_eq("rst_idx", 64'(o_idx), 64'd0);
        check_eq("rst_last", 64'(o_last), 64'd0);
        check_eq("rst_cfg_ready", 64'(o_cfg_ready), 64'd1);
        check_eq("rst_ready", 64'(o_ready), 64'd1);
        i_rst = 1'b0;
        tick();

        // Nominal, ReLU and linear cases
        do_cfg(1073741824, 0, -128, 1'b0, 4, 1'b0);
        send(1000, 1'b1); i_valid = 1'b0; drain();
        send(-5, 1'b1);   i_valid = 1'b0; drain();
        do_cfg(1073741824, 0, -128, 1'b1, 4, 1'b0);
        send(-1000, 1'b1); i_valid = 1'b0; drain();

        // Rounding, back to back
        do_cfg(1073741824, 0, 0, 1'b0, 8, 1'b0);
        send(3, 1'b1); send(1, 1'b0); send(0, 1'b0); i_valid = 1'b0; drain();

        // Backpressure mid-stream, then wrap past len
        do_cfg(1073741824, 0, 5, 1'b0, 4, 1'b0);
        fork
            begin
                send(10, 1'b0); send(20, 1'b0); send(30, 1'b0); send(40, 1'b0);
                i_valid = 1'b0;
            end
            begin
                tick(); tick();
                i_ready = 1'b0;
                repeat (5) tick();
                i_ready = 1'b1;
            end
        join
        send(50, 1'b0); i_valid = 1'b0; drain();

        // Config gated while items in flight; index resets on load
        do_cfg(1073741824, 0, 0, 1'b1, 4, 1'b0);
        send(7, 1'b0); send(9, 1'b0); i_valid = 1'b0;
        do_cfg(536870912, 0, 3, 1'b1, 3, 1'b1);
        send(11, 1'b0); send(-13, 1'b0); i_valid = 1'b0; drain();

        // Accumulator wins over a simultaneous config request
        i_cfg_mult = 32'h1234_5678; i_cfg_shift = 32'd5; i_cfg_out_zp = 8'h40;
        i_cfg_linear = 1'b0; i_cfg_len = 10'd9; i_cfg_valid = 1'b1;
        i_valid = 1'b1; i_acc = 32'd100;
        @(negedge i_clk);
        check_eq("cfg_vs_valid", 64'(o_cfg_ready), 64'd0);
        q.push_back('{ref_act(100), cyc, 1'b1});
        tick();
        i_valid = 1'b0; i_cfg_valid = 1'b0;
        drain();
        send(200, 1'b1); i_valid = 1'b0; drain();

        // Reset with three items in flight
        do_cfg(1073741824, 0, 0, 1'b1, 8, 1'b0);
        i_ready = 1'b0;
        send(1, 1'b0); send(2, 1'b0); send(3, 1'b0); i_valid = 1'b0;
        #2;
        i_rst = 1'b1;
        #1;
        check_eq("midrst_valid", 64'(o_valid), 64'd0);
        check_eq("midrst_cfg_ready", 64'(o_cfg_ready), 64'd1);
        check_eq("midrst_act", 64'(o_act), 64'd0);
        check_eq("midrst_idx", 64'(o_idx), 64'd0);
        q.delete();
        head_seen = 1'b0;
        m_mult = 0; m_shift = 0; m_zp = 0; m_lin = 1'b0; m_len = 0; m_idx = 0;
        i_ready = 1'b1;
        repeat (3) @(posedge i_clk);
        #2;
        i_rst = 1'b0;
        repeat (6) tick();
        check_eq("post_rst_quiet", 64'(o_valid), 64'd0);
        // Cleared config still produces defined output
        send(12345, 1'b1); i_valid = 1'b0; drain();

        // Randomized rounds
        for (int round = 0; round < 6; round++) begin
            do_cfg(int'($urandom), int'($urandom_range(0, 61)) - 31,
                   int'($urandom_range(0, 255)) - 128, 1'($urandom_range(0, 1)),
                   int'($urandom_range(1, 9)), 1'b0);
            rdone = 1'b0;
            guard = 0;
            fork
                begin
                    for (int k = 0; k < 40; k++) begin
                        if ($urandom_range(0, 4) == 0) begin
                            i_valid = 1'b0;
                            tick();
                        end
                        send(int'($urandom), 1'b0);
                    end
                    i_valid = 1'b0;
                    rdone   = 1'b1;
                end
                begin
                    while (!rdone && guard < 5000) begin
                        tick();
                        i_ready = ($urandom_range(0, 3) != 0);
                        guard++;
                    end
                end
            join
            i_ready = 1'b1;
            drain();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/requant_stage.md
Name: requant_stage

Overview:
Streaming requantization stage that sits directly downstream of the FC-layer dot-product/accumulate engine in the MNIST inference datapath. It takes one 32-bit accumulator per output neuron (bias already added) and applies optional ReLU, the fixed-point multiplier, the round-half-up right shift and the output zero-point. It emits the int8 activation that is written to the layer output buffer. Results are bit-exact with the golden exact-multiplier output files.

Parameters:
ACC_W, 32, accumulator and quant-multiplier width
OUT_W, 8, output activation width
IDX_W, 10, width of neuron index and layer-length fields

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous active-high reset
i_cfg_valid  in  1  config load request
o_cfg_ready  out  1  config may be accepted (pipeline empty)
i_cfg_mult  in  ACC_W  quant multiplier (signed)
i_cfg_shift  in  ACC_W  quant shift (signed); total_shift = 31 - i_cfg_shift
i_cfg_out_zp  in  8  output zero-point (signed)
i_cfg_linear  in  1  1 = no ReLU (last layer), 0 = ReLU
i_cfg_len  in  IDX_W  neurons in layer (1..1023)
i_valid  in  1  accumulator valid
o_ready  out  1  stage can accept accumulator
i_acc  in  ACC_W  signed accumulator incl. bias
o_valid  out  1  output activation valid
i_ready  in  1  downstream accepts output
o_act  out  OUT_W  requantized activation
o_idx  out  IDX_W  neuron index of o_act
o_last  out  1  o_act is final neuron of layer

Behaviour:
- Reset (async, immediate): all stage valids 0, o_valid=0, o_act=0, o_idx=0, o_last=0, config regs 0 (mult=0, shift=0, zp=0, linear=0, len=0), o_cfg_ready=1.
- Config: o_cfg_ready = no stage valid AND i_valid=0. Load on i_cfg_valid & o_cfg_ready; the neuron counter clears to 0 on load. Config is ignored when o_cfg_ready=0. Simultaneous i_valid and i_cfg_valid: the accumulator wins and the config is not loaded.
- Pipeline: 3 registered stages, latency 3 cycles from accepted input to o_valid, throughput 1/cycle.
  S1: r = linear ? acc : (acc<0 ? 0 : acc).
  S2: p = r * mult (signed 64-bit product).
  S3: t = p + (1 << (ts-1)), where ts = 31 - shift; s = t >>> ts (arithmetic); o_act = (s[15:0] + sign-extended zp)[7:0].
- Arithmetic: the 16-bit sum is truncated to 8 bits. There is no saturation; wrap-around is required for golden-file match. ts is legal only in 1..62; out-of-range config is undefined and the bench must not drive it.
- Handshake: accept on i_valid & o_ready; output transfer on o_valid & i_ready. Global stall: o_ready = !o_valid | i_ready. All stages hold while stalled. No bubble insertion: a full pipeline stalled for N cycles resumes with no loss or duplication. o_act, o_idx and o_last are stable while o_valid & !i_ready.
- Index: o_idx is attached at S3 from a counter that increments on each output transfer. o_last = (o_idx == len-1). The counter wraps to 0 after the last transfer. Inputs beyond len simply continue from index 0.
- Mid-operation reset: in-flight data is dropped, outputs return to reset values and config clears; the block must be reconfigured before use.

Test Plan:
- Nominal: cfg mult=1073741824, shift=0, zp=-128, linear=0, len=4. Drive acc=1000 -> o_act=0x74 (500-128), o_idx=0, o_valid exactly 3 cycles after accept.
- ReLU vs linear: acc=-5, linear=0, zp=-128 -> 0x80. Reconfigure linear=1 and drive acc=-1000 -> s=-500, o_act=0x8C.
- Rounding: mult=2^30, shift=0, zp=0. acc=3 -> 0x02; acc=1 -> 0x01; acc=0 -> 0x00.
- Backpressure: stream 4 accs with i_ready low for 5 cycles mid-stream -> o_ready drops, outputs hold stable, all 4 results arrive in order with idx 0..3, o_last only on idx 3, counter then wraps to 0.
- Config gating: assert i_cfg_valid while 2 items are in flight -> o_cfg_ready=0 and the config is ignored. The config is accepted the cycle after the pipeline drains and the index is reset.
- Reset mid-stream: assert i_rst with 3 items in flight -> o_valid=0 immediately, nothing emitted afterward, o_cfg_ready=1.
